// File: rtl/uio_sum_serial_tx_if.sv
// uio_sum_serial_tx_if: operand, control and uio pin bundle between a host and uio_sum_serial_tx
interface uio_sum_serial_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic              start;
   logic [7:0]        uio_in;
   logic [7:0]        uio_out;
   logic [7:0]        uio_oe;
   logic [DATA_W:0]   sum_out;
   logic              busy;
   logic              done;
   logic              err;
   modport master (output a_in, b_in, start, uio_in, input uio_out, uio_oe, sum_out, busy, done, err);
   modport slave (input a_in, b_in, start, uio_in, output uio_out, uio_oe, sum_out, busy, done, err);
endinterface

// File: rtl/uio_sum_serial_tx.sv
// uio_sum_serial_tx: latches a_in+b_in on start, shifts it LSB-first on uio pins, then waits for ack on uio_in[7]
// Defining UIO_TX_PARITY_EN appends an even-parity bit after the carry bit.
module uio_sum_serial_tx #(
   parameter int DATA_W = 8,
   parameter int CLK_DIV = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input logic clk,
   input logic rst,
   uio_sum_serial_tx_if.slave bus
);
`ifdef UIO_TX_PARITY_EN
   localparam int NB = DATA_W + 2;
`else
   localparam int NB = DATA_W + 1;
`endif
   localparam int PW = $clog2(CLK_DIV);
   localparam int BW = $clog2(NB);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_ACK} state_t;
   state_t state;
   logic [NB-1:0] shreg;
   logic [PW-1:0] phase;
   logic [BW-1:0] bit_idx;
   logic [TW-1:0] tcnt;
   logic [1:0] ack_sync;
   logic sdata, sclk, frame, oe;
   logic [DATA_W:0] sum;
   logic [NB-1:0] payload;
   assign sum = {1'b0, bus.a_in} + {1'b0, bus.b_in};
`ifdef UIO_TX_PARITY_EN
   assign payload = {^sum, sum};
`else
   assign payload = sum;
`endif
   assign bus.uio_out = {5'b0, frame, sclk, sdata};
   assign bus.uio_oe = {5'b0, {3{oe}}};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         phase <= '0;
         bit_idx <= '0;
         tcnt <= '0;
         ack_sync <= '0;
         sdata <= 1'b0;
         sclk <= 1'b0;
         frame <= 1'b0;
         oe <= 1'b0;
         bus.sum_out <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.err <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[0], bus.uio_in[7]};
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start && !bus.done) begin
               state <= SHIFT;
               shreg <= payload;
               bus.sum_out <= sum;
               bus.err <= 1'b0;
               bus.busy <= 1'b1;
               oe <= 1'b1;
               frame <= 1'b1;
               sdata <= payload[0];
               sclk <= 1'b0;
               phase <= '0;
               bit_idx <= '0;
            end
            SHIFT: if (phase == PH_LAST) begin
               phase <= '0;
               sclk <= 1'b0;
               if (bit_idx == BIT_LAST) begin
                  state <= WAIT_ACK;
                  frame <= 1'b0;
                  sdata <= 1'b0;
                  tcnt <= '0;
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  shreg <= shreg >> 1;
                  sdata <= shreg[1];
               end
            end else begin
               phase <= phase + 1'b1;
               sclk <= (phase + 1'b1) >= PH_HALF;
            end
            // a synced ack in the same cycle as the timeout still counts as success
            WAIT_ACK: if (ack_sync[1] || tcnt == TO_LAST) begin
               state <= IDLE;
               bus.done <= 1'b1;
               bus.err <= !ack_sync[1];
               bus.busy <= 1'b0;
               oe <= 1'b0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
